// File: rtl/eaglesong_pkg.sv
// Shared types and constants for the Eaglesong nonce-search controller.
package eaglesong_pkg;

   localparam int DIGEST_BYTES    = 32;
   localparam int DIGEST_W        = 256;
   localparam int DEFAULT_NONCE_W = 64;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_WAIT,
      ST_CHECK,
      ST_REPORT
   } state_t;

endpackage

// File: rtl/eaglesong_target_cmp.sv
// Unsigned hash <= target comparator, reduced as a tree of 32-bit slice results
// so a pipeline register can later be placed between any two tree levels.
module eaglesong_target_cmp
   import eaglesong_pkg::*;
(
   input  logic [DIGEST_W-1:0] hash,
   input  logic [DIGEST_W-1:0] target,
   output logic                le
);

   localparam int SLICE_W = 32;
   localparam int NS      = DIGEST_W / SLICE_W;

   logic [NS-1:0]   lt0, eq0;
   logic [NS/2-1:0] lt1, eq1;
   logic [NS/4-1:0] lt2, eq2;
   logic            lt3, eq3;

   generate
      for (genvar gi = 0; gi < NS; gi++) begin : g_slice
         assign lt0[gi] = hash[gi*SLICE_W +: SLICE_W] <  target[gi*SLICE_W +: SLICE_W];
         assign eq0[gi] = hash[gi*SLICE_W +: SLICE_W] == target[gi*SLICE_W +: SLICE_W];
      end
      // Each merge: the upper half decides unless it is equal.
      for (genvar gi = 0; gi < NS/2; gi++) begin : g_lvl1
         assign lt1[gi] = lt0[2*gi+1] | (eq0[2*gi+1] & lt0[2*gi]);
         assign eq1[gi] = eq0[2*gi+1] & eq0[2*gi];
      end
      for (genvar gi = 0; gi < NS/4; gi++) begin : g_lvl2
         assign lt2[gi] = lt1[2*gi+1] | (eq1[2*gi+1] & lt1[2*gi]);
         assign eq2[gi] = eq1[2*gi+1] & eq1[2*gi];
      end
   endgenerate

   assign lt3 = lt2[1] | (eq2[1] & lt2[0]);
   assign eq3 = eq2[1] & eq2[0];
   assign le  = lt3 | eq3;

endmodule

// File: rtl/eaglesong_nonce_search_ctrl.sv
// Drives one Eaglesong digest through a nonce range, stopping at the first
// hash that does not exceed the job target.
module eaglesong_nonce_search_ctrl
   import eaglesong_pkg::*;
#(
   parameter int NONCE_W     = DEFAULT_NONCE_W,
   parameter int TIMEOUT_CYC = 4096,
   parameter int HCNT_W      = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    job_valid,
   output logic                    job_ready,
   input  logic [DIGEST_W-NONCE_W-1:0] job_header,
   input  logic [DIGEST_W-1:0]     job_target,
   input  logic [NONCE_W-1:0]      job_nonce_start,
   input  logic [NONCE_W-1:0]      job_nonce_count,
   input  logic                    abort,
   output logic [DIGEST_W-1:0]     dig_input_val,
   output logic [6:0]              dig_input_length_bytes,
   output logic                    dig_start_eval,
   input  logic [DIGEST_W-1:0]     dig_output_val,
   input  logic                    dig_eval_output_ready,
   output logic                    found_valid,
   input  logic                    found_ready,
   output logic [NONCE_W-1:0]      found_nonce,
   output logic [DIGEST_W-1:0]     found_hash,
   output logic                    done,
   output logic                    exhausted,
   output logic                    timeout_err,
   output logic [HCNT_W-1:0]       hashes_tried,
   output logic                    busy
);

   localparam int HDR_W = DIGEST_W - NONCE_W;
   localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WD_W-1:0]    WD_LAST   = WD_W'(TIMEOUT_CYC - 1);
   localparam logic [NONCE_W-1:0] NONCE_ONE = NONCE_W'(1);
   localparam logic [HCNT_W-1:0]  HCNT_ONE  = HCNT_W'(1);

   state_t              state_reg, state_next;
   logic [HDR_W-1:0]    header_reg;
   logic [DIGEST_W-1:0] target_reg, hash_reg, found_hash_reg;
   logic [NONCE_W-1:0]  nonce_reg, remaining_reg, found_nonce_reg;
   logic [WD_W-1:0]     watchdog_reg;
   logic [HCNT_W-1:0]   hashes_reg;
   logic                found_valid_reg, exhausted_reg, timeout_reg;
   logic                hit, accept, wd_expired, last_nonce;

   assign accept     = (state_reg == ST_IDLE) && job_valid && !abort;
   assign wd_expired = (watchdog_reg == WD_LAST);
   assign last_nonce = (remaining_reg == NONCE_ONE);

   eaglesong_target_cmp u_cmp (
      .hash   (hash_reg),
      .target (target_reg),
      .le     (hit)
   );

   always_comb begin
      state_next = state_reg;
      done       = 1'b0;
      if (abort) begin
         state_next = ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (job_valid) begin
                  if (job_nonce_count == '0) done = 1'b1;
                  else                       state_next = ST_START;
               end
            end
            ST_START: state_next = ST_WAIT;
            ST_WAIT: begin
               // Ready is only trusted here: START has already re-armed the digest.
               if (dig_eval_output_ready) begin
                  state_next = ST_CHECK;
               end else if (wd_expired) begin
                  done       = 1'b1;
                  state_next = ST_IDLE;
               end
            end
            ST_CHECK: begin
               if (hit) begin
                  state_next = ST_REPORT;
               end else if (last_nonce) begin
                  done       = 1'b1;
                  state_next = ST_IDLE;
               end else begin
                  state_next = ST_START;
               end
            end
            ST_REPORT: begin
               if (found_ready) begin
                  done       = 1'b1;
                  state_next = ST_IDLE;
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= ST_IDLE;
         header_reg      <= '0;
         target_reg      <= '0;
         hash_reg        <= '0;
         found_hash_reg  <= '0;
         nonce_reg       <= '0;
         remaining_reg   <= '0;
         found_nonce_reg <= '0;
         watchdog_reg    <= '0;
         hashes_reg      <= '0;
         found_valid_reg <= 1'b0;
         exhausted_reg   <= 1'b0;
         timeout_reg     <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (abort) begin
            found_valid_reg <= 1'b0;
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  if (accept) begin
                     header_reg    <= job_header;
                     target_reg    <= job_target;
                     nonce_reg     <= job_nonce_start;
                     remaining_reg <= job_nonce_count;
                     hashes_reg    <= '0;
                     timeout_reg   <= 1'b0;
                     exhausted_reg <= (job_nonce_count == '0);
                  end
               end
               ST_START: watchdog_reg <= '0;
               ST_WAIT: begin
                  if (dig_eval_output_ready) begin
                     hash_reg <= dig_output_val;
                     if (hashes_reg != '1) hashes_reg <= hashes_reg + HCNT_ONE;
                  end else if (wd_expired) begin
                     timeout_reg <= 1'b1;
                  end else begin
                     watchdog_reg <= watchdog_reg + WD_W'(1);
                  end
               end
               ST_CHECK: begin
                  if (hit) begin
                     found_nonce_reg <= nonce_reg;
                     found_hash_reg  <= hash_reg;
                     found_valid_reg <= 1'b1;
                  end else if (last_nonce) begin
                     exhausted_reg <= 1'b1;
                  end else begin
                     nonce_reg     <= nonce_reg + NONCE_ONE;
                     remaining_reg <= remaining_reg - NONCE_ONE;
                  end
               end
               ST_REPORT: begin
                  if (found_ready) found_valid_reg <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   assign job_ready              = (state_reg == ST_IDLE);
   assign busy                   = (state_reg != ST_IDLE);
   assign dig_input_val          = {header_reg, nonce_reg};
   assign dig_input_length_bytes = 7'(DIGEST_BYTES);
   assign dig_start_eval         = (state_reg == ST_START);
   assign found_valid            = found_valid_reg;
   assign found_nonce            = found_nonce_reg;
   assign found_hash             = found_hash_reg;
   assign exhausted              = exhausted_reg;
   assign timeout_err            = timeout_reg;
   assign hashes_tried           = hashes_reg;

endmodule

// File: tb/tb_eaglesong_nonce_search_ctrl.sv
// Scoreboard bench: expected digest inputs and job-end records are queued at
// stimulus time and consumed by monitors when the controller presents them.
module tb_eaglesong_nonce_search_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         job_valid, job_ready;
   logic [191:0] job_header;
   logic [255:0] job_target;
   logic [63:0]  job_nonce_start, job_nonce_count;
   logic         abort;
   logic [255:0] dig_input_val;
   logic [6:0]   dig_input_length_bytes;
   logic         dig_start_eval;
   logic [255:0] dig_output_val = 256'hBAD;
   logic         dig_eval_output_ready = 1'b1;
   logic         found_valid, found_ready;
   logic [63:0]  found_nonce;
   logic [255:0] found_hash;
   logic         done, exhausted, timeout_err, busy;
   logic [31:0]  hashes_tried;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int           kind;   // 0 found, 1 exhausted, 2 timeout
      logic [63:0]  nonce;
      logic [255:0] hash;
      int           hashes;
   } end_t;

   logic [255:0] start_q[$];
   end_t         end_q[$];
   logic [63:0]  exp_found_nonce;

   always #5 clk = ~clk;

   eaglesong_nonce_search_ctrl #(
      .NONCE_W     (64),
      .TIMEOUT_CYC (16),
      .HCNT_W      (32)
   ) dut (
      .clk                    (clk),
      .rst                    (rst),
      .job_valid              (job_valid),
      .job_ready              (job_ready),
      .job_header             (job_header),
      .job_target             (job_target),
      .job_nonce_start        (job_nonce_start),
      .job_nonce_count        (job_nonce_count),
      .abort                  (abort),
      .dig_input_val          (dig_input_val),
      .dig_input_length_bytes (dig_input_length_bytes),
      .dig_start_eval         (dig_start_eval),
      .dig_output_val         (dig_output_val),
      .dig_eval_output_ready  (dig_eval_output_ready),
      .found_valid            (found_valid),
      .found_ready            (found_ready),
      .found_nonce            (found_nonce),
      .found_hash             (found_hash),
      .done                   (done),
      .exhausted              (exhausted),
      .timeout_err            (timeout_err),
      .hashes_tried           (hashes_tried),
      .busy                   (busy)
   );

   function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // Digest stand-in: top hash bits are the inverted nonce, so a rising nonce
   // walks the hash downward towards the target.
   function automatic logic [255:0] dig_hash(logic [255:0] d);
      return {~d[63:0], d[255:64]};
   endfunction

   int           lat      = 2;
   bit           dig_mute = 1'b0;
   int           pend_cnt = 0;
   logic [255:0] pend_din = '0;

   always @(posedge clk) begin
      if (dig_start_eval) begin
         pend_din              <= dig_input_val;
         pend_cnt              <= lat;
         dig_eval_output_ready <= 1'b0;
      end else if (pend_cnt > 0) begin
         pend_cnt <= pend_cnt - 1;
         if (pend_cnt == 1 && !dig_mute) begin
            dig_eval_output_ready <= 1'b1;
            dig_output_val        <= dig_hash(pend_din);
         end
      end
   end

   // Monitor: every start pulse must carry the next expected message.
   always @(negedge clk) begin
      if (!rst && dig_start_eval) begin
         $display("start din=%h", dig_input_val);
         if (start_q.size() == 0) chk("start_unexpected", 1'b1, 1'b0);
         else chk("start_din", dig_input_val, start_q.pop_front());
      end
   end

   // Monitor: every done pulse must match the next expected job end.
   always begin
      end_t e;
      @(negedge clk);
      if (!rst && done) begin
         if (end_q.size() == 0) begin
            chk("done_unexpected", 1'b1, 1'b0);
         end else begin
            e = end_q.pop_front();
            $display("done kind=%0d nonce=%h hashes=%0d", e.kind, e.nonce, e.hashes);
            if (e.kind == 0) begin
               chk("end_found_valid", found_valid, 1'b1);
               chk("end_found_nonce", found_nonce, e.nonce);
               chk("end_found_hash", found_hash, e.hash);
            end
            @(negedge clk);
            chk("end_hashes_tried", hashes_tried, 32'(e.hashes));
            chk("end_exhausted", exhausted, e.kind == 1);
            chk("end_timeout_err", timeout_err, e.kind == 2);
            chk("end_found_cleared", found_valid, 1'b0);
            chk("end_busy", busy, 1'b0);
         end
      end
   end

   // mode 0: run to its end, 1: expect watchdog, 2: interrupted (no end record)
   task automatic issue(input logic [191:0] hdr, input logic [255:0] tgt,
                        input logic [63:0] start, input logic [63:0] cnt, input int mode);
      end_t         e;
      logic [63:0]  n;
      logic [255:0] din, h;
      bit           hit_seen = 1'b0;
      int           tried = 0;
      n = start;
      e.kind = 1; e.nonce = '0; e.hash = '0;
      for (int i = 0; i < int'(cnt) && !hit_seen; i++) begin
         din = {hdr, n};
         start_q.push_back(din);
         tried++;
         if (mode == 1) break;
         h = dig_hash(din);
         if (h <= tgt) begin
            hit_seen = 1'b1; e.kind = 0; e.nonce = n; e.hash = h;
            exp_found_nonce = n;
         end else begin
            n = n + 64'd1;
         end
      end
      e.hashes = tried;
      if (mode == 1) begin e.kind = 2; e.hashes = 0; end
      if (mode != 2) end_q.push_back(e);
      @(posedge clk); #1;
      job_header = hdr; job_target = tgt; job_nonce_start = start; job_nonce_count = cnt;
      job_valid = 1'b1;
      @(posedge clk); #1;
      job_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      do begin @(negedge clk); k++; end while (busy && k < 2000);
      if (busy) chk("wait_idle_expired", 1'b1, 1'b0);
   endtask

   task automatic wait_found();
      int k = 0;
      do begin @(negedge clk); k++; end while (!found_valid && k < 2000);
      if (!found_valid) chk("wait_found_expired", 1'b1, 1'b0);
   endtask

   task automatic wait_start();
      int k = 0;
      do begin @(negedge clk); k++; end while (!dig_start_eval && k < 200);
      if (!dig_start_eval) chk("wait_start_expired", 1'b1, 1'b0);
   endtask

   task automatic finish_found(input int hold);
      wait_found();
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("found_hold_valid", found_valid, 1'b1);
         chk("found_hold_nonce", found_nonce, exp_found_nonce);
      end
      @(posedge clk); #1 found_ready = 1'b1;
      @(posedge clk); #1 found_ready = 1'b0;
   endtask

   localparam logic [191:0] HDR_A = 192'hA5A5_0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_5A5A_1111_2222;
   localparam logic [191:0] HDR_B = 192'h0BAD_F00D_0000_0000_0000_0000_0000_0000_0000_0000_CAFE_0001;
   localparam logic [255:0] TGT_EQ7 = {~64'd7, 192'd0};

   initial begin
      int n;
      rst = 1'b1; job_valid = 1'b0; abort = 1'b0; found_ready = 1'b0;
      job_header = '0; job_target = '0; job_nonce_start = '0; job_nonce_count = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_job_ready", job_ready, 1'b1);
      chk("rst_len", dig_input_length_bytes, 7'd32);
      chk("rst_busy", busy, 1'b0);
      chk("rst_start", dig_start_eval, 1'b0);
      chk("rst_din", dig_input_val, '0);
      chk("rst_found_valid", found_valid, 1'b0);
      chk("rst_flags", {done, exhausted, timeout_err}, 3'b000);
      chk("rst_hashes", hashes_tried, '0);
      @(posedge clk); #1 rst = 1'b0;

      // Immediate hit, result held against backpressure.
      issue(HDR_A, '1, 64'd5, 64'd3, 0);
      finish_found(3);
      wait_idle();

      // No hit possible; nonce wraps through zero.
      issue(HDR_A, '0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd4, 0);
      wait_idle();

      // Empty range: done in the accept cycle, no digest started.
      issue(HDR_A, '1, 64'd9, 64'd0, 0);
      wait_idle();

      // Equality with target counts as a hit; one above does not.
      issue(192'd0, TGT_EQ7, 64'd5, 64'd5, 0);
      finish_found(0);
      wait_idle();
      issue(192'd1, TGT_EQ7, 64'd5, 64'd5, 0);
      finish_found(0);
      wait_idle();

      // Ready still high from the previous job; only the new hash may land.
      lat = 10;
      issue(HDR_B, '1, 64'd100, 64'd2, 0);
      finish_found(1);
      wait_idle();
      lat = 2;

      // Digest never answers: watchdog fires 16 cycles into WAIT.
      dig_mute = 1'b1;
      issue(HDR_A, '1, 64'd50, 64'd2, 1);
      wait_start();
      n = 0;
      do begin @(negedge clk); n++; end while (!done && n < 100);
      chk("timeout_cycles", 32'(n), 32'd16);
      wait_idle();
      dig_mute = 1'b0;

      // Reset during WAIT takes effect without a clock edge.
      lat = 10;
      issue(HDR_A, '1, 64'd1, 64'd1, 2);
      wait_start();
      repeat (3) @(negedge clk);
      @(posedge clk); #1 rst = 1'b1;
      #1;
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_job_ready", job_ready, 1'b1);
      chk("midrst_din", dig_input_val, '0);
      chk("midrst_hashes", hashes_tried, '0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (12) @(negedge clk);
      chk("midrst_still_idle", busy, 1'b0);
      lat = 2;

      // Abort while a result is offered: back to IDLE, no done.
      issue(HDR_A, '1, 64'd3, 64'd2, 2);
      wait_found();
      @(posedge clk); #1 abort = 1'b1;
      @(negedge clk);
      chk("abort_no_done", done, 1'b0);
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      chk("abort_busy", busy, 1'b0);
      chk("abort_found_valid", found_valid, 1'b0);
      chk("abort_job_ready", job_ready, 1'b1);

      // Abort and job offered together in IDLE: job is dropped.
      @(posedge clk); #1;
      job_header = HDR_A; job_target = '1; job_nonce_start = 64'd7; job_nonce_count = 64'd3;
      job_valid = 1'b1; abort = 1'b1;
      @(negedge clk);
      chk("abort_job_no_done", done, 1'b0);
      @(posedge clk); #1 job_valid = 1'b0; abort = 1'b0;
      repeat (2) @(negedge clk);
      chk("abort_job_busy", busy, 1'b0);

      repeat (5) @(negedge clk);
      chk("start_q_drained", 32'(start_q.size()), 32'd0);
      chk("end_q_drained", 32'(end_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/eaglesong_nonce_search_ctrl.md
Name: eaglesong_nonce_search_ctrl

Overview:
Initiator-side controller for the Eaglesong digest core's start_eval / eval_output_ready handshake. It accepts a mining job (header prefix, target, nonce range) and builds each 32-byte message as header || nonce. It pulses start_eval, waits for the digest, compares the hash against the target, and either reports a winning nonce or advances to the next one. It sits between the job-dispatch logic and one digest instance.

Parameters:
NONCE_W, 64, nonce width in bits; header prefix width is 256-NONCE_W
TIMEOUT_CYC, 4096, max cycles allowed in WAIT before the error is raised
HCNT_W, 32, width of the saturating hashes-tried counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
job_valid  in  1  job offered
job_ready  out  1  controller idle and able to accept a job
job_header  in  256-NONCE_W  message prefix, placed at bits [255:NONCE_W]
job_target  in  256  unsigned threshold; bit 255 is the MSB
job_nonce_start  in  NONCE_W  first nonce tried
job_nonce_count  in  NONCE_W  number of nonces to try
abort  in  1  drop the current job
dig_input_val  out  256  to digest input_val
dig_input_length_bytes  out  7  to digest; constant 7'd32
dig_start_eval  out  1  one-cycle start pulse to digest
dig_output_val  in  256  digest result
dig_eval_output_ready  in  1  digest result valid
found_valid  out  1  winning result held
found_ready  in  1  consumer accepts result
found_nonce  out  NONCE_W  winning nonce
found_hash  out  256  winning hash
done  out  1  one-cycle pulse at job end (found-and-accepted, exhausted, or timeout)
exhausted  out  1  sticky until next job: range finished with no hit
timeout_err  out  1  sticky until next job: WAIT exceeded TIMEOUT_CYC
hashes_tried  out  HCNT_W  saturating count of digests completed in the current job
busy  out  1  state != IDLE

Behaviour:
- Reset (async, any state): state=IDLE, every output 0 except job_ready=1, dig_input_length_bytes=32. All data registers are cleared.
- States: IDLE, START, WAIT, CHECK, REPORT.
- IDLE: on job_valid&&job_ready, latch header, target, nonce=job_nonce_start, remaining=job_nonce_count. Clear exhausted, timeout_err and hashes_tried.
  - count==0: pulse done, set exhausted, stay in IDLE; no digest is started.
  - otherwise go to START.
- START: dig_input_val={header,nonce} is held stable from START through WAIT. dig_start_eval=1 for exactly this one cycle. Watchdog cleared. Go to WAIT.
- WAIT: dig_eval_output_ready is sampled only from the cycle after the start pulse. The digest leaves ready high from the previous evaluation, and before its first start the value is undefined; the controller must never sample it in IDLE or START.
  - On ready=1: capture dig_output_val into hash_q, increment hashes_tried (saturating), go to CHECK.
  - Watchdog reaches TIMEOUT_CYC: set timeout_err, pulse done, go to IDLE.
- CHECK: hit = (hash_q <= target), 256-bit unsigned.
  - hit: load found_nonce=nonce and found_hash=hash_q, set found_valid, go to REPORT.
  - miss, remaining==1: set exhausted, pulse done, go to IDLE.
  - miss, otherwise: nonce<=nonce+1 (wraps mod 2^NONCE_W), remaining<=remaining-1, go to START.
- REPORT: found_valid and its data stay stable until found_ready. On the accept cycle, clear found_valid, pulse done, go to IDLE. The search stops on the first hit; there is no continuation.
- Minimum per-nonce overhead: START + CHECK = 2 cycles plus digest latency.
- abort: async-priority is not required. It is sampled every cycle, has priority over all transitions, and returns the controller to IDLE on the next edge.
  - found_valid is cleared; done is not pulsed; exhausted and timeout_err are unchanged.
  - An in-flight digest result is ignored; its ready level is harmless because START always re-arms.
- job_valid while busy: ignored (job_ready=0).
- job_valid and abort in the same IDLE cycle: abort wins; the job is not accepted.

Decomposition:
- eaglesong_pkg holds:
  - the state enum type;
  - DIGEST_BYTES=32;
  - DIGEST_W=256;
  - default NONCE_W.
- One natural sub-module, eaglesong_target_cmp: 256-bit unsigned <= comparator built as a 32-bit-slice compare tree, so a register stage can be inserted later.

Test Plan:
1. job nonce_start=5, count=3, target=all ones -> a single start pulse; found_nonce=5; found_valid held through 3 cycles of found_ready=0; done pulses on the accept cycle; hashes_tried=1.
2. target=0 (no hit is possible), count=4, nonce_start=2^64-2 -> digest inputs use nonces FFFF..FE, FFFF..FF, 0, 1; then exhausted=1, done pulse, hashes_tried=4.
3. count=0 -> done pulse and exhausted=1 in the accept cycle; dig_start_eval never asserts.
4. digest model holds ready=1 from the prior job during START, then delivers a new result after 10 cycles -> only the new hash is captured.
5. digest model never asserts ready, TIMEOUT_CYC=16 -> timeout_err=1 and done pulse exactly 16 cycles into WAIT; controller returns to IDLE.
6. rst asserted mid-WAIT, and separately abort in REPORT -> rst gives outputs at reset values in the same cycle; abort gives IDLE next edge, found_valid=0, no done pulse.
